// File: rtl/fc_l2_stream_decoder_if.sv
// Bus between the layer-2 stream decoder and its host: stream input, decode control and result handshake.
// Result handshake: a result transfers on any rising clk edge where out_valid and out_ready are both high.
interface fc_l2_stream_decoder_if #(
    parameter int N        = 8,
    parameter int WIN_LOG2 = 8
);
    localparam int VW = WIN_LOG2 + 2;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic            start;
    logic            abort;
    logic            en;
    logic [N-1:0]    stream;
    logic            out_ready;
    logic [N*VW-1:0] val;
    logic [IW-1:0]   win_idx;
    logic            out_valid;
    logic            busy;
    logic [2:0]      dbg_state;

    modport master (
        output start, abort, en, stream, out_ready,
        input  val, win_idx, out_valid, busy, dbg_state
    );

    modport slave (
        input  start, abort, en, stream, out_ready,
        output val, win_idx, out_valid, busy, dbg_state
    );
endinterface

// File: rtl/fc_l2_stream_decoder.sv
// Accumulates N stochastic node bitstreams over a 2^WIN_LOG2 sample window, converts the counts to
// signed (bipolar) or unsigned values and scans for the winning node.
module fc_l2_stream_decoder #(
    parameter int N        = 8,
    parameter int WIN_LOG2 = 8,
    parameter int SETTLE   = 3,
    parameter bit BIPOLAR  = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    init_i,
    fc_l2_stream_decoder_if.slave   bus_io
);
    localparam int L  = 1 << WIN_LOG2;
    localparam int CW = WIN_LOG2 + 1;
    localparam int VW = WIN_LOG2 + 2;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_ACCUM  = 3'd2,
        S_ARGMAX = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   settle_q;
    logic [CW-1:0]   sample_q;
    logic [CW-1:0]   ones_q [N];
    logic [IW-1:0]   scan_q;
    logic [CW-1:0]   best_q;
    logic [IW-1:0]   best_idx_q;
    logic [IW-1:0]   win_idx_q;
    logic [N*VW-1:0] val_q;

    logic [CW-1:0]   cand;
    logic            take;
    logic [CW-1:0]   scan_best;
    logic [IW-1:0]   scan_best_idx;

    function automatic logic [VW-1:0] conv(input logic [CW-1:0] ones);
        logic [VW-1:0] u;
        u = {1'b0, ones};
        if (BIPOLAR) return (u << 1) - VW'(L);
        else return u;
    endfunction

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (bus_io.start) state_d = (SETTLE == 0) ? S_ACCUM : S_SETTLE;
            S_SETTLE: if (bus_io.en && settle_q == SW'(1)) state_d = S_ACCUM;
            S_ACCUM:  if (bus_io.en && sample_q == CW'(L - 1)) state_d = S_ARGMAX;
            S_ARGMAX: if (scan_q == IW'(N - 1)) state_d = S_DONE;
            S_DONE:   if (bus_io.out_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if (bus_io.abort) state_d = S_IDLE;
    end

    // Counts are monotonic in the converted value, so the scan compares raw counts.
    always_comb begin
        cand          = ones_q[scan_q];
        take          = (scan_q == '0) || (cand > best_q);
        scan_best     = take ? cand : best_q;
        scan_best_idx = take ? scan_q : best_idx_q;
    end

    always_ff @(posedge clk_i or posedge init_i) begin
        if (init_i) begin
            state_q    <= S_IDLE;
            settle_q   <= '0;
            sample_q   <= '0;
            scan_q     <= '0;
            best_q     <= '0;
            best_idx_q <= '0;
            win_idx_q  <= '0;
            val_q      <= '0;
            for (int j = 0; j < N; j++) ones_q[j] <= '0;
        end else begin
            state_q <= state_d;
            if (bus_io.abort || state_q == S_IDLE) begin
                settle_q <= (state_q == S_IDLE && bus_io.start && !bus_io.abort) ? SW'(SETTLE) : '0;
                sample_q <= '0;
                scan_q   <= '0;
                for (int j = 0; j < N; j++) ones_q[j] <= '0;
            end else begin
                case (state_q)
                    S_SETTLE: if (bus_io.en) settle_q <= settle_q - 1'b1;
                    S_ACCUM: if (bus_io.en) begin
                        sample_q <= sample_q + 1'b1;
                        for (int j = 0; j < N; j++) ones_q[j] <= ones_q[j] + CW'(bus_io.stream[j]);
                    end
                    S_ARGMAX: begin
                        scan_q     <= scan_q + 1'b1;
                        best_q     <= scan_best;
                        best_idx_q <= scan_best_idx;
                        if (scan_q == '0) begin
                            for (int j = 0; j < N; j++) val_q[j*VW +: VW] <= conv(ones_q[j]);
                        end
                        if (scan_q == IW'(N - 1)) win_idx_q <= scan_best_idx;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus_io.val       = val_q;
    assign bus_io.win_idx   = win_idx_q;
    assign bus_io.out_valid = (state_q == S_DONE);
    assign bus_io.busy      = (state_q != S_IDLE);
    assign bus_io.dbg_state = state_q;
endmodule
